bcd_event_counter: RTL and testbench

- Parametrised successor to the scoreboard hit counter: a DIGITS-wide BCD counter clocked by the system clock rather than by the event line.
- The asynchronous fire input is synchronised and edge-detected, then counted up or down.
- Supports wrap or saturate at the range limits and reports sticky overflow/underflow flags.
- The packed BCD output feeds the LED display state machine directly.

---
 rtl/bcd_event_counter.sv | 166 ++++++++++++++++
 tb/tb_bcd_event_counter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_event_counter.sv
// -----------------------------------------------------------------------------
// bcd_event_counter
//
// Purpose:
//   DIGITS-wide packed BCD up/down event counter running on the system clock.
//   The asynchronous fire line is synchronised, rising-edge detected and the
//   resulting one-cycle event is applied to the count, with either wrap or
//   saturate behaviour at the range limits and sticky overflow/underflow flags.
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   reset      asynchronous active-low reset (release expected synchronous)
//   fire       asynchronous event line, each 0->1 transition is one event
//   error      synchronous inhibit, drops a detected event
//   dir        1 = count up, 0 = count down, sampled in the event cycle
//   clear      synchronous clear of count and flags (highest priority)
//   bcd        packed count, digit k in bits [4k+3:4k]
//   accepted   one-cycle strobe, coincident with the bcd update
//   overflow   sticky, up-count attempted at the maximum
//   underflow  sticky, down-count attempted at zero
// -----------------------------------------------------------------------------

// One BCD digit of the increment/decrement chain. cin_i is the carry (up) or
// borrow (down) arriving from the digit below; digit 0 gets a constant 1.
module bcd_event_counter_digit (
    input  logic       up_i,
    input  logic       cin_i,
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o,
    output logic       cout_o
);
    always_comb begin
        digit_o = digit_i;
        cout_o  = 1'b0;
        if (cin_i) begin
            if (up_i) begin
                // >= 9 folds any corrupt code back into the legal range
                if (digit_i >= 4'd9) begin
                    digit_o = 4'd0;
                    cout_o  = 1'b1;
                end else begin
                    digit_o = digit_i + 4'd1;
                end
            end else begin
                if (digit_i == 4'd0) begin
                    digit_o = 4'd9;
                    cout_o  = 1'b1;
                end else if (digit_i > 4'd9) begin
                    digit_o = 4'd9;
                end else begin
                    digit_o = digit_i - 4'd1;
                end
            end
        end
    end
endmodule

module bcd_event_counter #(
    parameter int DIGITS      = 3,
    parameter int SYNC_STAGES = 2,
    parameter bit WRAP        = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fire,
    input  logic                  error,
    input  logic                  dir,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  accepted,
    output logic                  overflow,
    output logic                  underflow
);

    // ---------------------------------------------------------------------
    // fire synchroniser and edge detect
    // ---------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   fire_last_q;
    logic                   evt_q;

    // evt_q is registered so it is valid in the cycle after edge
    // SYNC_STAGES+1, and the count update lands on edge SYNC_STAGES+2.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q      <= '0;
            fire_last_q <= 1'b0;
            evt_q       <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], fire};
            fire_last_q <= sync_q[SYNC_STAGES-1];
            evt_q       <= sync_q[SYNC_STAGES-1] & ~fire_last_q;
        end
    end

    // ---------------------------------------------------------------------
    // BCD digit chain
    // ---------------------------------------------------------------------
    logic [DIGITS-1:0][3:0] bcd_q, bcd_d;
    logic [DIGITS-1:0][3:0] step;
    logic [DIGITS:0]        cy;

    assign cy[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_event_counter_digit u_digit (
            .up_i    (dir),
            .cin_i   (cy[g]),
            .digit_i (bcd_q[g]),
            .digit_o (step[g]),
            .cout_o  (cy[g+1])
        );
    end

    // A carry/borrow out of the top digit means every digit was at its
    // limit (all 9s going up, all 0s going down). In that case step[] is
    // already the wrapped value, so wrap mode needs no extra logic.
    logic at_limit;
    assign at_limit = cy[DIGITS];

    // ---------------------------------------------------------------------
    // Next state: clear > error > evt
    // ---------------------------------------------------------------------
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;
    logic acc_q, acc_d;

    always_comb begin
        bcd_d = bcd_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        acc_d = 1'b0;
        if (clear) begin
            bcd_d = '0;
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else if (evt_q && !error) begin
            acc_d = 1'b1;
            if (at_limit) begin
                if (dir) ovf_d = 1'b1;
                else     unf_d = 1'b1;
            end
            if (WRAP || !at_limit) bcd_d = step;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcd_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            acc_q <= 1'b0;
        end else begin
            bcd_q <= bcd_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            acc_q <= acc_d;
        end
    end

    assign bcd       = bcd_q;
    assign accepted  = acc_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_bcd_event_counter.sv
// Scoreboard bench: two counters (wrap and saturate) share the stimulus. Each
// issued event pushes the expected post-event state into a per-DUT queue; a
// monitor pops and compares whenever accepted is seen.
module tb_bcd_event_counter;
    localparam int MAXV = 999;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic fire = 1'b0, error = 1'b0, dir = 1'b1, clear = 1'b0;
    logic [11:0] bcd_a [2];
    logic        acc_a [2];
    logic        ov_a  [2];
    logic        un_a  [2];

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bcd_event_counter #(.DIGITS(3), .SYNC_STAGES(2), .WRAP(1'b1)) dut_w (
        .clk(clk), .reset(rst_n), .fire(fire), .error(error), .dir(dir),
        .clear(clear), .bcd(bcd_a[0]), .accepted(acc_a[0]),
        .overflow(ov_a[0]), .underflow(un_a[0]));

    bcd_event_counter #(.DIGITS(3), .SYNC_STAGES(2), .WRAP(1'b0)) dut_s (
        .clk(clk), .reset(rst_n), .fire(fire), .error(error), .dir(dir),
        .clear(clear), .bcd(bcd_a[1]), .accepted(acc_a[1]),
        .overflow(ov_a[1]), .underflow(un_a[1]));

    typedef struct {
        logic [11:0] bcd;
        logic        ov;
        logic        un;
        int          cyc;
    } exp_t;

    exp_t q [2][$];
    int   cnt [2];
    bit   mov [2];
    bit   mun [2];
    int   checks = 0;
    int   passed = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        r[3:0]  = 4'(v % 10);
        r[7:4]  = 4'((v / 10) % 10);
        r[11:8] = 4'((v / 100) % 10);
        return r;
    endfunction

    function automatic int digits_ok(input logic [11:0] v);
        logic [11:0] t;
        t = v;
        for (int k = 0; k < 3; k++) begin
            if (t[3:0] > 4'd9) return 0;
            t = t >> 4;
        end
        return 1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            cnt[i] = 0; mov[i] = 1'b0; mun[i] = 1'b0;
        end
    endtask

    // Reference integer model; index 0 wraps, index 1 saturates.
    task automatic model_apply(input bit up, input int accept_cyc);
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (up) begin
                if (cnt[i] == MAXV) begin
                    mov[i] = 1'b1;
                    if (i == 0) cnt[i] = 0;
                end else cnt[i]++;
            end else begin
                if (cnt[i] == 0) begin
                    mun[i] = 1'b1;
                    if (i == 0) cnt[i] = MAXV;
                end else cnt[i]--;
            end
            e.bcd = to_bcd(cnt[i]); e.ov = mov[i]; e.un = mun[i]; e.cyc = accept_cyc;
            q[i].push_back(e);
        end
    endtask

    // One clean fire pulse. dir holds the wrong value until the event cycle
    // (after edge 3) to show only the event-cycle value matters; error and
    // clear are also driven in that cycle.
    task automatic do_event(input bit d, input bit err, input bit clr);
        int t;
        @(posedge clk); #1;
        fire = 1'b1; dir = ~d; t = cyc;
        repeat (3) @(posedge clk);
        #1;
        fire = 1'b0; dir = d; error = err; clear = clr;
        if (clr) model_clear();
        else if (!err) model_apply(d, t + 4);
        @(posedge clk); #1;
        error = 1'b0; clear = 1'b0;
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_both(input string name, input int exp_w, input int exp_s);
        chk({name, " wrap bcd"}, bcd_a[0], exp_w);
        chk({name, " sat bcd"},  bcd_a[1], exp_s);
    endtask

    // Monitor
    always @(negedge clk) begin : mon
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (acc_a[i] === 1'b1) begin
                if (q[i].size() == 0) begin
                    chk(i == 0 ? "wrap unexpected accepted" : "sat unexpected accepted", 1, 0);
                end else begin
                    e = q[i].pop_front();
                    chk(i == 0 ? "wrap bcd" : "sat bcd", bcd_a[i], e.bcd);
                    chk(i == 0 ? "wrap overflow" : "sat overflow", ov_a[i], e.ov);
                    chk(i == 0 ? "wrap underflow" : "sat underflow", un_a[i], e.un);
                    chk(i == 0 ? "wrap accept cycle" : "sat accept cycle", cyc, e.cyc);
                    chk(i == 0 ? "wrap digits legal" : "sat digits legal", digits_ok(bcd_a[i]), 1);
                end
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        model_clear();
        void'($urandom(32'h5eed));
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset bcd", bcd_a[i], 0);
            chk("reset accepted", acc_a[i], 0);
            chk("reset overflow", ov_a[i], 0);
            chk("reset underflow", un_a[i], 0);
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        repeat (12) do_event(1'b1, 1'b0, 1'b0);
        drain();
        chk_both("12 ups", 12'h012, 12'h012);
        chk("12 ups overflow", ov_a[0], 0);

        repeat (87) do_event(1'b1, 1'b0, 1'b0);
        drain();
        chk_both("to 099", 12'h099, 12'h099);
        do_event(1'b1, 1'b0, 1'b0);
        drain();
        chk_both("099 up", 12'h100, 12'h100);
        do_event(1'b0, 1'b0, 1'b0);
        drain();
        chk_both("100 down", 12'h099, 12'h099);

        repeat (900) do_event(1'b1, 1'b0, 1'b0);
        drain();
        chk_both("to 999", 12'h999, 12'h999);
        do_event(1'b1, 1'b0, 1'b0);
        drain();
        chk_both("999 up", 12'h000, 12'h999);
        chk("999 up wrap overflow", ov_a[0], 1);
        chk("999 up sat overflow", ov_a[1], 1);
        do_event(1'b0, 1'b0, 1'b0);
        drain();
        chk_both("down after limit", 12'h999, 12'h998);
        chk("000 down wrap underflow", un_a[0], 1);
        chk("sat underflow not set", un_a[1], 0);

        // plain clear
        @(posedge clk); #1; clear = 1'b1;
        @(posedge clk); #1; clear = 1'b0;
        model_clear();
        chk_both("clear", 12'h000, 12'h000);
        chk("clear wrap overflow", ov_a[0], 0);
        chk("clear wrap underflow", un_a[0], 0);

        // fire held high for 50 cycles -> one event
        begin
            int t;
            @(posedge clk); #1;
            fire = 1'b1; dir = 1'b1; t = cyc;
            model_apply(1'b1, t + 4);
            repeat (50) @(posedge clk);
            #1; fire = 1'b0;
            drain();
            chk_both("fire held high", 12'h001, 12'h001);
        end

        // error during the event cycle drops it
        do_event(1'b1, 1'b1, 1'b0);
        drain();
        chk_both("error drop", 12'h001, 12'h001);

        // clear coincident with an event, with flags set beforehand
        do_event(1'b0, 1'b0, 1'b0);
        do_event(1'b0, 1'b0, 1'b0);
        drain();
        chk_both("0 down", 12'h999, 12'h000);
        chk("0 down sat underflow", un_a[1], 1);
        do_event(1'b1, 1'b0, 1'b1);
        drain();
        chk_both("clear with evt", 12'h000, 12'h000);
        chk("clear with evt wrap underflow", un_a[0], 0);
        chk("clear with evt sat underflow", un_a[1], 0);

        // asynchronous reset while an edge is in the synchroniser
        repeat (457) do_event(1'b1, 1'b0, 1'b0);
        drain();
        chk_both("to 457", 12'h457, 12'h457);
        @(posedge clk); #1; fire = 1'b1; dir = 1'b1;
        @(posedge clk); #4; rst_n = 1'b0;
        #1;
        chk_both("async reset", 12'h000, 12'h000);
        model_clear();
        fire = 1'b0;
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk_both("after reset release", 12'h000, 12'h000);

        // random stream against the integer model
        for (int n = 0; n < 2400; n++) begin
            do_event(1'($urandom_range(1)), ($urandom_range(7) == 0), ($urandom_range(63) == 0));
        end
        drain();
        chk("final wrap bcd", bcd_a[0], to_bcd(cnt[0]));
        chk("final sat bcd", bcd_a[1], to_bcd(cnt[1]));
        chk("wrap queue empty", q[0].size(), 0);
        chk("sat queue empty", q[1].size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
